// File: rtl/mem_access_stage.sv
// MEM stage of the pipelined MIPS CPU: handshaked data-memory loads/stores, front-end stall
// generation, and the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_i,
  input  logic        RegData_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [5:0]  Op_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] Data_i,
  input  logic [4:0]  Rd_i,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        RegWrite_o,
  output logic        RegData_o,
  output logic [31:0] MemData_o,
  output logic [31:0] ALUResult_o,
  output logic [4:0]  Rd_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [1:0] SzWord = 2'd0;
  localparam logic [1:0] SzByte = 2'd1;
  localparam logic [1:0] SzHalf = 2'd2;

  // Unknown opcodes carrying a memory request fall back to word size.
  function automatic logic [1:0] op_size(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: op_size = SzByte;
      6'h21, 6'h25, 6'h29: op_size = SzHalf;
      default:             op_size = SzWord;
    endcase
  endfunction

  state_e      state;
  logic [7:0]  cnt;
  logic [5:0]  lat_op;
  logic [1:0]  lat_off;
  logic        lat_store;
  logic        lat_regwrite;
  logic        lat_regdata;
  logic [31:0] lat_alu;
  logic [4:0]  lat_rd;
  logic [31:0] rdata_word;

  logic        mem_op;
  logic        misaligned;
  logic        start;
  logic [1:0]  size_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  always_comb begin
    size_c     = op_size(Op_i);
    mem_op     = MemRead_i | MemWrite_i;
    misaligned = ((size_c == SzWord) && (ALUResult_i[1:0] != 2'b00)) ||
                 ((size_c == SzHalf) && ALUResult_i[0]);
    case (size_c)
      SzByte: begin
        be_c    = 4'b0001 << ALUResult_i[1:0];
        wdata_c = {4{Data_i[7:0]}};
      end
      SzHalf: begin
        be_c    = ALUResult_i[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{Data_i[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = Data_i;
      end
    endcase
    start     = (state == StIdle) && mem_op && !misaligned;
    mem_stall = start || (state == StBusy);
  end

  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;

  always_comb begin
    lat_size   = op_size(lat_op);
    lat_signed = (lat_op == 6'h20) || (lat_op == 6'h21);
    case (lat_off)
      2'd0:    byte_v = rdata_word[7:0];
      2'd1:    byte_v = rdata_word[15:8];
      2'd2:    byte_v = rdata_word[23:16];
      default: byte_v = rdata_word[31:24];
    endcase
    half_v = lat_off[1] ? rdata_word[31:16] : rdata_word[15:0];
    case (lat_size)
      SzByte:  load_data = {{24{lat_signed & byte_v[7]}}, byte_v};
      SzHalf:  load_data = {{16{lat_signed & half_v[15]}}, half_v};
      default: load_data = rdata_word;
    endcase
    if (lat_store) load_data = 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      cnt          <= 8'h0;
      lat_op       <= 6'h0;
      lat_off      <= 2'b00;
      lat_store    <= 1'b0;
      lat_regwrite <= 1'b0;
      lat_regdata  <= 1'b0;
      lat_alu      <= 32'h0;
      lat_rd       <= 5'h0;
      rdata_word   <= 32'h0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'h0;
      dmem_be      <= 4'h0;
      dmem_wdata   <= 32'h0;
      RegWrite_o   <= 1'b0;
      RegData_o    <= 1'b0;
      MemData_o    <= 32'h0;
      ALUResult_o  <= 32'h0;
      Rd_o         <= 5'h0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;

      case (state)
        StIdle: begin
          if (start) begin
            dmem_req     <= 1'b1;
            dmem_we      <= MemWrite_i;
            dmem_addr    <= {ALUResult_i[31:2], 2'b00};
            dmem_be      <= be_c;
            dmem_wdata   <= wdata_c;
            lat_op       <= Op_i;
            lat_off      <= ALUResult_i[1:0];
            lat_store    <= MemWrite_i;
            lat_regwrite <= RegWrite_i;
            lat_regdata  <= RegData_i;
            lat_alu      <= ALUResult_i;
            lat_rd       <= Rd_i;
            cnt          <= 8'h0;
            state        <= StBusy;
          end
        end
        StBusy: begin
          if (dmem_ack) begin
            rdata_word <= dmem_rdata;
            dmem_req   <= 1'b0;
            state      <= StDone;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            rdata_word <= 32'h0;
            dmem_req   <= 1'b0;
            bus_err_o  <= 1'b1;
            state      <= StDone;
          end else begin
            cnt <= cnt + 8'h1;
          end
        end
        default: state <= StIdle;
      endcase

      // MEM/WB register: bubble while stalled, retire on DONE, else pass through.
      if (mem_stall) begin
        RegWrite_o <= 1'b0;
      end else if (state == StDone) begin
        RegWrite_o  <= lat_regwrite;
        RegData_o   <= lat_regdata;
        MemData_o   <= load_data;
        ALUResult_o <= lat_alu;
        Rd_o        <= lat_rd;
      end else if (!mem_op) begin
        RegWrite_o  <= RegWrite_i;
        RegData_o   <= RegData_i;
        MemData_o   <= 32'h0;
        ALUResult_o <= ALUResult_i;
        Rd_o        <= Rd_i;
      end else begin
        RegWrite_o <= 1'b0;
        misalign_o <= 1'b1;
      end
    end
  end

endmodule
